// File: rtl/nn_serial_pkg.sv
// Shared definitions for the binarized-input serial link (transmitter and receiver side).
package nn_serial_pkg;

    localparam int NUM_INPUTS = 784;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LOW,
        HIGH,
        DONE
    } tx_state_t;

    // A modulo-1 counter still needs one physical bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/serial_phase_counter.sv
// Modulo-MODULUS cycle counter with synchronous clear; terminal marks the last cycle of a period.
module serial_phase_counter
    import nn_serial_pkg::*;
#(
    parameter int MODULUS = 4
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    output logic terminal
);

    localparam int W = cnt_width(MODULUS);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count;

    assign terminal = (count == LAST);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_transmitter.sv
// Captures a binarized frame and shifts it MSB-first over the serialClock/serialData/serialReset link.
module serial_frame_transmitter
    import nn_serial_pkg::*;
#(
    parameter int numInputs = NUM_INPUTS,
    parameter int clkDiv    = 4,
    parameter int rstCycles = 2
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic [numInputs-1:0] frameIn,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 serialClock,
    output logic                 serialData,
    output logic                 serialReset
);

    localparam int BIT_W = $clog2(numInputs + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(numInputs - 1);

    tx_state_t state, next_state;

    logic [numInputs-1:0] shift_reg, shift_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic                 accept, phase_tc, rst_tc, bit_end;
    logic                 ready_next, done_next, sclk_next, sdata_next, sreset_next;

    assign accept  = start && ready;
    assign bit_end = (state == HIGH) && phase_tc;

    serial_phase_counter #(.MODULUS(clkDiv)) phase_counter (
        .clock   (clock),
        .resetN  (resetN),
        .clear   ((state != LOW) && (state != HIGH)),
        .terminal(phase_tc)
    );

    serial_phase_counter #(.MODULUS(rstCycles)) reset_counter (
        .clock   (clock),
        .resetN  (resetN),
        .clear   (state != RST),
        .terminal(rst_tc)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = RST;
            RST:     if (rst_tc)   next_state = LOW;
            LOW:     if (phase_tc) next_state = HIGH;
            HIGH:    if (phase_tc) next_state = (bit_cnt == LAST_BIT) ? DONE : LOW;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_next = shift_reg;
        bit_next   = bit_cnt;
        if (accept) begin
            shift_next = frameIn;
            bit_next   = '0;
        end else if (bit_end) begin
            shift_next = {shift_reg[numInputs-2:0], 1'b0};
            bit_next   = bit_cnt + 1'b1;
        end
    end

    // Link outputs are decoded from the next state and then registered, so every wire is glitch-free.
    always_comb begin
        ready_next  = (next_state == IDLE);
        done_next   = (next_state == DONE);
        sclk_next   = (next_state == HIGH);
        sreset_next = (next_state == RST);
        sdata_next  = 1'b0;
        case (next_state)
            LOW:     sdata_next = shift_next[numInputs-1];
            HIGH:    sdata_next = serialData;
            default: sdata_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ready       <= 1'b1;
            done        <= 1'b0;
            serialClock <= 1'b0;
            serialData  <= 1'b0;
            serialReset <= 1'b0;
        end else begin
            ready       <= ready_next;
            done        <= done_next;
            serialClock <= sclk_next;
            serialData  <= sdata_next;
            serialReset <= sreset_next;
        end
    end

endmodule

// File: doc/serial_frame_transmitter.md
# serial_frame_transmitter

Parallel-to-serial transmitter that drives the three-wire binarized-input link (serialClock, serialData, serial reset) into the network's input shift register. It captures a numInputs-bit binarized frame from the host side with a ready/start handshake, pulses the receiver reset, then shifts the frame out MSB-first on a divided, glitch-free serialClock. It sits on the host/stimulus side of the link, typically fed by the image loader or a UART/JTAG frame buffer.

## Interface
- numInputs, 784: frame length in bits (≥2).
- clkDiv, 4: system cycles per serialClock half-period (≥1).
- rstCycles, 2: system cycles serialReset is held high before the first bit (≥1).
- clock  in  1  system clock; all logic on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- frameIn  in  numInputs  binarized frame; bit i lands in receiver register bit i.
- start  in  1  request to send frameIn; accepted only when ready=1.
- ready  out  1  idle and able to accept start.
- done  out  1  one-cycle pulse after the last bit's high phase.
- serialClock  out  1  link clock to receiver (registered).
- serialData  out  1  link data to receiver (registered).
- serialReset  out  1  active-high receiver reset (registered).

## Operation
- States: IDLE, RST, LOW, HIGH, DONE.
- IDLE: ready=1, serialClock=0, serialData=0, serialReset=0. start&&ready at an edge captures frameIn into internal shift register, bitCnt=0, phaseCnt=0, next state RST. start while ready=0 ignored; frameIn not sampled outside acceptance edge.
- RST: serialReset=1 for exactly rstCycles cycles, then LOW.
- LOW: serialClock=0, serialData = shiftReg[numInputs-1] for clkDiv cycles, then HIGH.
- HIGH: serialClock=1, serialData held unchanged for clkDiv cycles. At end: shift register left by one, bitCnt+1; if bitCnt was numInputs-1 go DONE else LOW.
- DONE: one cycle, done=1, serialClock=0, serialData=0, ready=0; then IDLE.
- Bit order: frame bit numInputs-1 sent first, bit 0 last; with receiver shifting in at bit 0, receiver register equals frameIn after numInputs rising edges.
- serialData changes only on transitions into LOW (or on leaving HIGH to DONE); never in the same cycle serialClock rises.
- resetN low at any time (including mid-frame): immediate return to IDLE, all outputs to IDLE values, done=0, counters cleared; partial frame abandoned (next frame's serialReset cleans receiver).
- Counters: phaseCnt width $clog2(clkDiv) (min 1), wraps at clkDiv-1; bitCnt width $clog2(numInputs+1).

## Timing
- Reset values: ready=1, done=0, serialClock=0, serialData=0, serialReset=0.
- Start accepted at edge k: ready=0 from cycle k+1; serialReset high cycles k+1..k+rstCycles.
- Bit j (0-based) occupies cycles k+rstCycles+1+2j·clkDiv onward: clkDiv cycles low, clkDiv cycles high.
- done high in cycle k+rstCycles+2·clkDiv·numInputs+1; ready=1 the following cycle; earliest next accept that cycle.
- Busy duration: rstCycles+2·clkDiv·numInputs+1 cycles (784/4/2: 6275).
- serialClock period 2·clkDiv cycles, 50% duty, no glitches (all link outputs flop-driven).

## Structure
- Package nn_serial_pkg: state enum typedef (IDLE, RST, LOW, HIGH, DONE), NUM_INPUTS default constant 784 shared with the receiver.
- Sub-module serial_phase_counter: clkDiv-modulo counter with clear and terminal-count output; reused for RST timing with separate instance or load.
- Top holds FSM, frame shift register, bitCnt.

## Test plan
- numInputs=8, clkDiv=2, rstCycles=2, frameIn=8'hA5, start: serialReset high 2 cycles; bits 1,0,1,0,0,1,0,1 on serialClock rising edges; behavioral receiver holds 8'hA5; done at cycle k+35.
- Same config, frameIn=8'h00 then 8'hFF back-to-back (start held high): second accepted first cycle ready=1; receiver reads 8'hFF; serialReset pulsed before each frame.
- start pulsed while busy (mid-LOW and mid-HIGH): ignored, frame and timing unchanged, single done.
- resetN asserted during bit 4 high phase: all outputs 0, ready=1 asynchronously; new frame 8'h3C then received correctly.
- clkDiv=1, rstCycles=1, numInputs=8: serialClock toggles every cycle; busy 18 cycles; data stable at every rising edge.
- Default 784/4/2 random frame: receiver matches frameIn, busy exactly 6275 cycles.
